// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin burst arbiter in front of an 8x8 FIFO write port.
// Optional per-requester write counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic [7:0] a_data,
    output logic       a_ack,
    output logic       a_gnt,
    input  logic       b_req,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic       b_gnt,
    input  logic       fifo_full,
    output logic       fifo_wr,
    output logic [7:0] fifo_data
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [7:0] a_wcnt,
    output logic [7:0] b_wcnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic       PRI_A     = 1'b0;
    localparam logic       PRI_B     = 1'b1;
    localparam logic [3:0] CNT_LAST  = 4'(BURST_LEN - 1);

    state_t     state;
    state_t     next_state;
    logic       rr_pri;
    logic       rr_pri_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       burst_done;

    // State, round-robin pointer and burst counter; reset aborts any grant at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_pri <= PRI_A;
            cnt    <= 4'd0;
        end else begin
            state  <= next_state;
            rr_pri <= rr_pri_next;
            cnt    <= cnt_next;
        end
    end

    // Write path is purely combinational from the registered owner, so data is never buffered here.
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        fifo_wr   = 1'b0;
        fifo_data = 8'h00;
        unique case (state)
            GNT_A: begin
                a_gnt     = 1'b1;
                fifo_wr   = a_req & ~fifo_full;
                fifo_data = a_data;
            end
            GNT_B: begin
                b_gnt     = 1'b1;
                fifo_wr   = b_req & ~fifo_full;
                fifo_data = b_data;
            end
            default: begin
                fifo_data = 8'h00;
            end
        endcase
        a_ack      = fifo_wr & a_gnt;
        b_ack      = fifo_wr & b_gnt;
        burst_done = fifo_wr & (cnt == CNT_LAST);
    end

    // Next owner: a grant ends on request drop or on the last write of a burst, and the pointer flips.
    always_comb begin
        next_state  = state;
        rr_pri_next = rr_pri;
        cnt_next    = cnt;
        unique case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    next_state = (rr_pri == PRI_B) ? GNT_B : GNT_A;
                end else if (a_req) begin
                    next_state = GNT_A;
                end else if (b_req) begin
                    next_state = GNT_B;
                end
            end
            GNT_A: begin
                if (!a_req || burst_done) begin
                    rr_pri_next = PRI_B;
                    next_state  = b_req ? GNT_B : IDLE;
                end else if (fifo_wr) begin
                    cnt_next = cnt + 4'd1;
                end
            end
            GNT_B: begin
                if (!b_req || burst_done) begin
                    rr_pri_next = PRI_A;
                    next_state  = a_req ? GNT_A : IDLE;
                end else if (fifo_wr) begin
                    cnt_next = cnt + 4'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (next_state != state) begin
            cnt_next = 4'd0;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Free-running accepted-write counters, wrapping at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_wcnt <= 8'd0;
            b_wcnt <= 8'd0;
        end else begin
            if (a_ack) a_wcnt <= a_wcnt + 8'd1;
            if (b_ack) b_wcnt <= b_wcnt + 8'd1;
        end
    end
`endif

endmodule
